// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : des_key_sched
// Description : DES key schedule sequencer. It takes a post-PC-1 C||D key and
//               walks the 16 round rotations, left for encryption and right for
//               decryption. It presents one PC-2 compressed 48-bit subkey per
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched #(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [0:55] load_cd,
  input  logic        load_decrypt,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [0:47] k,
  output logic [3:0]  key_round,
  output logic        key_last,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] LAST_ROUND = 4'd15;

  // PC-2 selection table, zero-based indices into cd[0:55], output bit 0 first
  localparam logic [5:0] PC2_IDX [0:47] = '{
    6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,  6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
    6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,  6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
    6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54, 6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
    6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52, 6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
  };

  logic [0:0]  state_q, state_d;
  logic [0:55] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        dir_q, dir_d;

  logic        w_load_dec;
  logic        w_left;
  logic        w_two;
  logic [4:0]  w_sched_idx;

  // Rotate one 28-bit half by 1 or 2 places in the requested direction
  function automatic logic [0:27] rot28(input logic [0:27] x, input logic left, input logic two);
    logic [0:27] r;
    if (left) begin
      r = two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
    end else begin
      r = two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
    end
    return r;
  endfunction

  // Schedule entries 1, 2, 9 and 16 shift by one; every other round by two
  function automatic logic shift_is_two(input logic [4:0] idx);
    return !((idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16));
  endfunction

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign key_valid  = (state_q == ST_RUN);
  assign key_round  = round_q;
  assign key_last   = (state_q == ST_RUN) && (round_q == LAST_ROUND);

  // Direction of a new key; a build without decrypt support always encrypts
  assign w_load_dec = load_decrypt && DECRYPT_EN;

  // Decrypt walks the schedule backwards from K16, encrypt forwards from K2
  assign w_sched_idx = dir_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
  assign w_two       = shift_is_two(w_sched_idx);
  assign w_left      = !(dir_q && DECRYPT_EN);

  // Next-state logic: load, advance on handshake, return to idle after K-last
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d = ST_RUN;
          round_d = 4'd0;
          dir_d   = w_load_dec;
          // Decrypt starts from K16, whose cumulative rotation of 28 is the identity
          if (w_load_dec) begin
            cd_d = load_cd;
          end else begin
            cd_d = {rot28(load_cd[0:27], 1'b1, 1'b0), rot28(load_cd[28:55], 1'b1, 1'b0)};
          end
        end
      end
      ST_RUN: begin
        if (key_ready) begin
          if (round_q == LAST_ROUND) begin
            // cd and round are kept; only the handshake state returns to idle
            state_d = ST_IDLE;
          end else begin
            round_d = round_q + 4'd1;
            cd_d    = {rot28(cd_q[0:27], w_left, w_two), rot28(cd_q[28:55], w_left, w_two)};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      round_q <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

  // PC-2 compression of the registered cd value only
  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign k[gi] = cd_q[PC2_IDX[gi]];
  end

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_sched
// Description : Self-checking bench for des_key_sched with a subkey scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_sched;

  localparam int S_TAB [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int PC2_T [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32
  };
  localparam logic [55:0] FIPS_CD = 56'hF0CCAAF556678F;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_decrypt, key_ready;
  logic [0:55] load_cd;
  logic        load_ready, key_valid, key_last, busy;
  logic [0:47] k;
  logic [3:0]  key_round;
  logic        load_ready_n, key_valid_n, key_last_n, busy_n;
  logic [0:47] k_n;
  logic [3:0]  key_round_n;

  typedef struct {
    logic [47:0] k;
    logic [3:0]  r;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] keys [16];
  int          errors = 0;
  int          checks = 0;
  int          n_emit = 0;

  des_key_sched #(.DECRYPT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_cd(load_cd), .load_decrypt(load_decrypt), .key_valid(key_valid),
    .key_ready(key_ready), .k(k), .key_round(key_round), .key_last(key_last), .busy(busy)
  );

  des_key_sched #(.DECRYPT_EN(1'b0)) dut_noenc (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_n),
    .load_cd(load_cd), .load_decrypt(load_decrypt), .key_valid(key_valid_n),
    .key_ready(key_ready), .k(k_n), .key_round(key_round_n), .key_last(key_last_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  // Reference schedule: FIPS forward rotations then PC-2 on a [55:0] numbering
  function automatic void gen_keys(input logic [55:0] cd0);
    logic [27:0] c, d;
    logic [55:0] cd;
    c = cd0[55:28];
    d = cd0[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < S_TAB[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int b = 0; b < 48; b++) keys[i][47-b] = cd[56-PC2_T[b]];
    end
  endfunction

  // Drive one load handshake and queue the 16 expected subkeys
  task automatic start(input logic [55:0] cd0, input logic dec);
    exp_t e;
    gen_keys(cd0);
    for (int i = 0; i < 16; i++) begin
      e.k = dec ? keys[15-i] : keys[i];
      e.r = 4'(i);
      e.l = (i == 15);
      sb.push_back(e);
    end
    load_cd      = cd0;
    load_decrypt = dec;
    load_valid   = 1'b1;
    @(posedge clk);
    #1;
    load_valid   = 1'b0;
    load_decrypt = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted subkey is popped and compared
  always @(negedge clk) begin
    exp_t e;
    if (!rst && key_valid && key_ready) begin
      checks++;
      n_emit++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got k=%h round=%0d with no subkey expected", k, key_round);
      end else begin
        e = sb.pop_front();
        if (k !== e.k || key_round !== e.r || key_last !== e.l) begin
          errors++;
          $display("FAIL sb_subkey: got k=%h round=%0d last=%b, expected k=%h round=%0d last=%b",
                   k, key_round, key_last, e.k, e.r, e.l);
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    checks++;
    if ({key_valid, load_ready, busy, key_last, key_round} !== 8'b0100_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got v/lr/busy/last/round=%b, expected 01000000",
               {key_valid, load_ready, busy, key_last, key_round});
    end
    checks++;
    if (k !== 48'h0) begin errors++; $display("FAIL reset_k: got %h expected 0", k); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_valid, load_ready, busy, key_last, key_round} !== 8'b0100_0000 || k !== 48'h0) begin
      errors++;
      $display("FAIL post_reset: got ctrl=%b k=%h, expected ctrl=01000000 k=0",
               {key_valid, load_ready, busy, key_last, key_round}, k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_encrypt();
    int n0;
    n0 = n_emit;
    key_ready = 1'b1;
    start(FIPS_CD, 1'b0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b1) begin errors++; $display("FAIL enc_valid: cycle %0d got %b expected 1", c, key_valid); end
      if (c == 0) begin
        checks++;
        if (k !== 48'h1B02EFFC7072) begin errors++; $display("FAIL enc_K1: got %h expected 1b02effc7072", k); end
      end else if (c == 1) begin
        checks++;
        if (k !== 48'h79AED9DBC9E5) begin errors++; $display("FAIL enc_K2: got %h expected 79aed9dbc9e5", k); end
      end else if (c == 15) begin
        checks++;
        if (k !== 48'hCB3D8B0E17F5 || key_last !== 1'b1) begin
          errors++; $display("FAIL enc_K16: got k=%h last=%b expected cb3d8b0e17f5 last=1", k, key_last);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enc_end: got valid=%b load_ready=%b busy=%b expected 0 1 0", key_valid, load_ready, busy);
    end
    checks++;
    if (n_emit - n0 != 16 || sb.size() != 0) begin
      errors++; $display("FAIL enc_count: got %0d subkeys, %0d pending, expected 16 and 0", n_emit - n0, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_decrypt();
    bit to;
    key_ready = 1'b1;
    start(FIPS_CD, 1'b1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (k_n !== keys[c]) begin
        errors++; $display("FAIL noenc_order: emission %0d got %h expected %h", c, k_n, keys[c]);
      end
      if (c == 0) begin
        checks++;
        if (k !== 48'hCB3D8B0E17F5) begin errors++; $display("FAIL dec_first: got %h expected cb3d8b0e17f5", k); end
      end else if (c == 1) begin
        checks++;
        if (k !== 48'hBF918D3D3F0A) begin errors++; $display("FAIL dec_K15: got %h expected bf918d3d3f0a", k); end
      end else if (c == 15) begin
        checks++;
        if (k !== 48'h1B02EFFC7072) begin errors++; $display("FAIL dec_K1: got %h expected 1b02effc7072", k); end
      end
    end
    wait_idle(to);
    checks++;
    if (to || sb.size() != 0) begin errors++; $display("FAIL dec_done: timeout=%b pending=%0d expected 0 0", to, sb.size()); end
  endtask

  task automatic test_backpressure();
    bit to;
    int n0;
    n0 = n_emit;
    key_ready = 1'b1;
    start(FIPS_CD, 1'b0);
    repeat (4) @(posedge clk);
    #1 key_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b1 || key_round !== 4'd4 || k !== keys[4]) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b round=%0d k=%h expected 1 4 %h", key_valid, key_round, k, keys[4]);
      end
      @(posedge clk);
      #1;
    end
    key_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (key_round !== 4'd5 || k !== keys[5]) begin
      errors++; $display("FAIL bp_resume: got round=%0d k=%h expected 5 %h", key_round, k, keys[5]);
    end
    wait_idle(to);
    checks++;
    if (to || n_emit - n0 != 16 || sb.size() != 0) begin
      errors++; $display("FAIL bp_count: timeout=%b got %0d subkeys expected 16", to, n_emit - n0);
    end
  endtask

  task automatic test_load_busy();
    bit to;
    int n0;
    logic [55:0] key_a;
    key_a = {24'($urandom), $urandom};
    n0 = n_emit;
    key_ready = 1'b1;
    start(key_a, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    load_cd    = ~key_a;
    load_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0 || key_round !== 4'd7) begin
      errors++; $display("FAIL busy_ready: got load_ready=%b round=%0d expected 0 7", load_ready, key_round);
    end
    @(posedge clk);
    #1 load_valid = 1'b0;
    wait_idle(to);
    checks++;
    if (to || n_emit - n0 != 16 || sb.size() != 0) begin
      errors++; $display("FAIL busy_count: timeout=%b got %0d subkeys expected 16", to, n_emit - n0);
    end
  endtask

  task automatic test_async_reset();
    bit to;
    key_ready = 1'b1;
    start(FIPS_CD, 1'b0);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || k !== 48'h0 || load_ready !== 1'b1 || key_round !== 4'd0) begin
      errors++;
      $display("FAIL areset: got valid=%b busy=%b k=%h load_ready=%b round=%0d expected 0 0 0 1 0",
               key_valid, busy, k, load_ready, key_round);
    end
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || key_valid !== 1'b0) begin
      errors++; $display("FAIL areset_release: got load_ready=%b valid=%b expected 1 0", load_ready, key_valid);
    end
    @(posedge clk);
    #1;
    start(FIPS_CD, 1'b0);
    @(negedge clk);
    checks++;
    if (key_round !== 4'd0 || k !== 48'h1B02EFFC7072) begin
      errors++; $display("FAIL areset_restart: got round=%0d k=%h expected 0 1b02effc7072", key_round, k);
    end
    wait_idle(to);
    checks++;
    if (to || sb.size() != 0) begin errors++; $display("FAIL areset_done: timeout=%b pending=%0d", to, sb.size()); end
  endtask

  task automatic test_rotation();
    bit to;
    logic [47:0] ev;
    key_ready = 1'b1;
    for (int dec = 0; dec < 2; dec++) begin
      for (int pat = 0; pat < 2; pat++) begin
        ev = (pat == 1) ? 48'hFFFFFFFFFFFF : 48'h0;
        start((pat == 1) ? {56{1'b1}} : 56'h0, dec[0]);
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          checks++;
          if (k !== ev || k_n !== ev) begin
            errors++; $display("FAIL rot_const: dec=%0d emission %0d got %h/%h expected %h", dec, c, k, k_n, ev);
          end
        end
        wait_idle(to);
        checks++;
        if (to || sb.size() != 0) begin errors++; $display("FAIL rot_done: timeout=%b pending=%0d", to, sb.size()); end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    load_valid   = 1'b0;
    load_decrypt = 1'b0;
    load_cd      = '0;
    key_ready    = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_load_busy();
    test_async_reset();
    test_rotation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
